// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 inverse cipher, one round per clock.
// The key schedule is expanded once per key (one round key per cycle) into an
// internal 11-entry round-key file. Ciphertext blocks are then decrypted by
// walking that file backwards.
// Optional build macro AES_DEC_ZEROIZE_EN: clears the plaintext register on the
// output handshake, the round state on ROUND exit, and the key file on entry to
// key expansion. Without it, these registers keep their values until overwritten.
module aes_decrypt_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [Nk*32-1:0]   key_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       data_out,
    output logic               busy
);

    if (Nk != 4 || Nr != Nk + 6) begin : g_param_check
        $error("aes_decrypt_iter supports only Nk=4, Nr=10");
    end

    localparam logic [3:0] NR_CNT = 4'(Nr);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX_TBL[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        inv_sbox = INV_SBOX_TBL[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the state is row k%4, column k/4; byte 0 sits in the MSBs.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   x2 [4];
        logic [7:0]   x4 [4];
        logic [7:0]   x8 [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8 * (4 * c + r) -: 8];
                x2[r] = xtime(a[r]);
                x4[r] = xtime(x2[r]);
                x8[r] = xtime(x4[r]);
            end
            // Coefficients: 0e = x8^x4^x2, 0b = x8^x2^1, 0d = x8^x4^1, 09 = x8^1
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] =
                    (x8[r] ^ x4[r] ^ x2[r]) ^
                    (x8[(r + 1) % 4] ^ x2[(r + 1) % 4] ^ a[(r + 1) % 4]) ^
                    (x8[(r + 2) % 4] ^ x4[(r + 2) % 4] ^ a[(r + 2) % 4]) ^
                    (x8[(r + 3) % 4] ^ a[(r + 3) % 4]);
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t;
        logic [31:0] w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e       state_r, next_state_s;
    logic [127:0] rk_r [0:Nr];
    logic [127:0] st_r;
    logic [3:0]   rnd_r;
    logic [3:0]   kcnt_r;
    logic         key_loaded_r;
    logic [127:0] data_out_r;
    logic         out_valid_r;
    logic         busy_r;
    logic         key_fire_s, in_fire_s;
    logic [127:0] isb_s, ark_s, imc_s, key_next_s;

    assign isb_s      = inv_sub_bytes(inv_shift_rows(st_r));
    assign ark_s      = isb_s ^ rk_r[rnd_r];
    assign imc_s      = inv_mix_columns(ark_s);
    assign key_next_s = expand_key(rk_r[kcnt_r - 4'd1], rcon(kcnt_r));
    assign key_fire_s = key_valid & key_ready;
    assign in_fire_s  = in_valid & in_ready;
    assign data_out   = data_out_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;

    // Next-state decode and handshake readiness; a pending key always beats ciphertext.
    always_comb begin
        next_state_s = state_r;
        key_ready    = 1'b0;
        in_ready     = 1'b0;
        case (state_r)
            IDLE: begin
                key_ready = 1'b1;
                in_ready  = key_loaded_r & ~key_valid;
                if (key_valid) begin
                    next_state_s = KEYEXP;
                end else if (in_valid && key_loaded_r) begin
                    next_state_s = ROUND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            KEYEXP: begin
                if (kcnt_r == NR_CNT) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = KEYEXP;
                end
            end
            ROUND: begin
                if (rnd_r == 4'd0) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ROUND;
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    next_state_s = in_valid ? ROUND : IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == KEYEXP) || (next_state_s == ROUND);
        end
    end

    // Round datapath, key-expansion counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r         <= 128'd0;
            rnd_r        <= 4'd0;
            kcnt_r       <= 4'd0;
            key_loaded_r <= 1'b0;
            data_out_r   <= 128'd0;
            out_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_fire_s) begin
                        key_loaded_r <= 1'b0;
                        kcnt_r       <= 4'd1;
                    end else if (in_fire_s) begin
                        st_r  <= data_in ^ rk_r[Nr];
                        rnd_r <= NR_CNT - 4'd1;
                    end
                end
                KEYEXP: begin
                    kcnt_r <= kcnt_r + 4'd1;
                    if (kcnt_r == NR_CNT) begin
                        key_loaded_r <= 1'b1;
                    end
                end
                ROUND: begin
                    if (rnd_r != 4'd0) begin
                        st_r  <= imc_s;
                        rnd_r <= rnd_r - 4'd1;
                    end else begin
                        data_out_r  <= ark_s;
                        out_valid_r <= 1'b1;
`ifdef AES_DEC_ZEROIZE_EN
                        st_r        <= 128'd0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
                        data_out_r  <= 128'd0;
`endif
                    end
                    if (in_fire_s) begin
                        st_r  <= data_in ^ rk_r[Nr];
                        rnd_r <= NR_CNT - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key file: no reset needed, contents are only trusted once key_loaded is set.
    always_ff @(posedge clk) begin
        if (key_fire_s) begin
`ifdef AES_DEC_ZEROIZE_EN
            for (int i = 1; i <= Nr; i++) begin
                rk_r[i] <= 128'd0;
            end
`endif
            rk_r[0] <= key_in;
        end else if (state_r == KEYEXP) begin
            rk_r[kcnt_r] <= key_next_s;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 AES-128 vectors.
module tb_aes_decrypt_iter;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ONE  = 128'd1;
    localparam logic [127:0] ZERO = 128'd0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid, key_ready;
    logic [127:0] key_in;
    logic         in_valid, in_ready;
    logic [127:0] data_in;
    logic         out_valid, out_ready;
    logic [127:0] data_out;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int n;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        key_in = 128'd0; data_in = 128'd0;
        tick(); tick();

        // Reset values
        check("rst_key_ready", 128'(key_ready), ONE);
        check("rst_in_ready", 128'(in_ready), ZERO);
        check("rst_out_valid", 128'(out_valid), ZERO);
        check("rst_data_out", data_out, ZERO);
        check("rst_busy", 128'(busy), ZERO);

        // Ciphertext before any key: never accepted
        rst_n = 1'b1; in_valid = 1'b1; data_in = C1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("nokey_in_ready", 128'(in_ready), ZERO);
            tick();
        end
        check("nokey_out_valid", 128'(out_valid), ZERO);
        check("nokey_busy", 128'(busy), ZERO);

        // Key and ciphertext together: key wins
        key_valid = 1'b1; key_in = K1;
        #1;
        check("both_in_ready", 128'(in_ready), ZERO);
        check("both_key_ready", 128'(key_ready), ONE);
        tick();
        key_valid = 1'b0; in_valid = 1'b0; data_in = 128'd0;
        check("kexp_key_ready", 128'(key_ready), ZERO);
        check("kexp_in_ready", 128'(in_ready), ZERO);
        n = 0;
        while (busy && n < 30) begin n++; tick(); end
        check("k1_busy_cycles", 128'(n), 128'd10);
        check("k1_in_ready", 128'(in_ready), ONE);
        check("k1_out_valid", 128'(out_valid), ZERO);

        // Decrypt vector 1 and measure latency
        in_valid = 1'b1; data_in = C1;
        tick();
        in_valid = 1'b0; data_in = 128'd0;
        check("c1_busy", 128'(busy), ONE);
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("c1_latency", 128'(n), 128'd10);
        check("c1_plaintext", data_out, P1);

        // Backpressure: output held, nothing accepted
        in_valid = 1'b1; data_in = C1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("hold_out_valid", 128'(out_valid), ONE);
            check("hold_data_out", data_out, P1);
            check("hold_in_ready", 128'(in_ready), ZERO);
            check("hold_key_ready", 128'(key_ready), ZERO);
            tick();
        end

        // Back-to-back accept in DONE
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 128'(in_ready), ONE);
        tick();
        out_ready = 1'b0; in_valid = 1'b0; data_in = 128'd0;
        check("b2b_out_valid_drop", 128'(out_valid), ZERO);
        check("b2b_busy", 128'(busy), ONE);
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("b2b_latency", 128'(n), 128'd10);
        check("b2b_plaintext", data_out, P1);

        // Final handshake, then post-handshake data_out
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_out_valid", 128'(out_valid), ZERO);
`ifdef AES_DEC_ZEROIZE_EN
        check("post_data_out", data_out, ZERO);
`else
        check("post_data_out", data_out, P1);
`endif
        check("post_busy", 128'(busy), ZERO);
        check("post_key_ready", 128'(key_ready), ONE);

        // Second key, round-key check, vector 2
        key_valid = 1'b1; key_in = K2;
        tick();
        key_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin n++; tick(); end
        check("k2_busy_cycles", 128'(n), 128'd10);
        check("k2_rk10", dut.rk_r[10], RK10);
        in_valid = 1'b1; data_in = C2;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("c2_latency", 128'(n), 128'd10);
        check("c2_plaintext", data_out, P2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of the rounds
        in_valid = 1'b1; data_in = C2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), ZERO);
        check("midrst_data_out", data_out, ZERO);
        check("midrst_in_ready", 128'(in_ready), ZERO);
        check("midrst_busy", 128'(busy), ZERO);
        check("midrst_key_ready", 128'(key_ready), ONE);
        tick();
        rst_n = 1'b1; in_valid = 1'b1; data_in = C2;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("postrst_in_ready", 128'(in_ready), ZERO);
            tick();
        end
        check("postrst_out_valid", 128'(out_valid), ZERO);

        // Reload key, then the same ciphertext decrypts again
        key_valid = 1'b1; key_in = K2;
        #1;
        check("reload_in_ready", 128'(in_ready), ZERO);
        tick();
        key_valid = 1'b0; in_valid = 1'b0;
        n = 0;
        while (busy && n < 30) begin n++; tick(); end
        check("reload_busy_cycles", 128'(n), 128'd10);
        in_valid = 1'b1; data_in = C2;
        #1;
        check("reload_accept", 128'(in_ready), ONE);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        check("reload_latency", 128'(n), 128'd10);
        check("reload_plaintext", data_out, P2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
